// File: rtl/csi_rx_pkg.sv
// csi_rx_pkg: shared types, DT codes and header-ECC tables for the CSI-2 packet handler
package csi_rx_pkg;
  typedef enum logic [1:0] {IDLE, PAYLOAD, GAP} state_t;
  typedef struct packed {
    logic [7:0]  ecc;
    logic [15:0] wc;
    logic [7:0]  di;
  } hdr_t;
  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_LS = 6'h02;
  localparam logic [5:0] DT_LE = 6'h03;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;
  localparam logic [4:0] BIT_NONE = 5'd31;
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };
  function automatic logic [4:0] syndrome_to_bit(input logic [5:0] syn);
    logic [4:0] idx;
    idx = BIT_NONE;
    for (int i = 0; i < 24; i++) idx = (syn == ECC_COL[i]) ? 5'(i) : idx;
    return idx;
  endfunction
endpackage

// File: rtl/csi_rx_hdr_ecc.sv
// csi_rx_hdr_ecc: 6-bit CSI-2 header ECC over the 24 header data bits
module csi_rx_hdr_ecc
  import csi_rx_pkg::*;
(
  input  logic [23:0] data_i,
  output logic [5:0]  ecc_o
);
  // XOR together the column pattern of every set data bit
  always_comb begin
    ecc_o = 6'd0;
    for (int i = 0; i < 24; i++) ecc_o = ecc_o ^ (data_i[i] ? ECC_COL[i] : 6'd0);
  end
endmodule

// File: rtl/csi_rx_packet_handler.sv
// csi_rx_packet_handler: CSI-2 header check/correct, short-packet sync decode and long-packet payload streaming
module csi_rx_packet_handler
  import csi_rx_pkg::*;
#(
  parameter logic [1:0] VC_SEL = 2'd0,
  parameter bit ECC_CORRECT = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        sync_wait_o,
  output logic [31:0] payload_o,
  output logic        payload_valid_o,
  output logic [3:0]  payload_keep_o,
  output logic        payload_last_o,
  output logic [5:0]  data_type_o,
  output logic [15:0] word_count_o,
  output logic        in_frame_o,
  output logic        in_line_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic        ecc_corrected_o,
  output logic        ecc_error_o,
  output logic [15:0] ecc_err_cnt_o
);
  state_t      state_q;
  hdr_t        hdr;
  logic [5:0]  ecc, syn, dt;
  logic [4:0]  bit_idx;
  logic [23:0] fixed;
  logic [15:0] wc, remaining_q, data_left_q, ecc_err_cnt_q, word_count_q;
  logic        hit_data, hit_ecc, hdr_ok, vc_ok, vc_ok_q;
  logic [31:0] payload_q;
  logic [3:0]  payload_keep_q;
  logic [5:0]  data_type_q;
  logic        sync_wait_q, payload_valid_q, payload_last_q, in_frame_q, in_line_q;
  logic        frame_start_q, frame_end_q, line_start_q, line_end_q, ecc_corrected_q, ecc_error_q;
  logic        unused_ecc_hi;

  assign hdr = data_i;
  assign unused_ecc_hi = ^hdr.ecc[7:6];

  csi_rx_hdr_ecc u_ecc (.data_i(data_i[23:0]), .ecc_o(ecc));

  // Header decode: syndrome classification and single-bit repair of the data field
  always_comb begin
    syn = ecc ^ hdr.ecc[5:0];
    bit_idx = syndrome_to_bit(syn);
    hit_data = bit_idx != BIT_NONE;
    hit_ecc = (syn != 6'd0) && ((syn & (syn - 6'd1)) == 6'd0);
    fixed = {hdr.wc, hdr.di} ^ ((ECC_CORRECT && hit_data) ? (24'd1 << bit_idx) : 24'd0);
    hdr_ok = (syn == 6'd0) || (ECC_CORRECT && (hit_data || hit_ecc));
    dt = fixed[5:0];
    wc = fixed[23:8];
    vc_ok = fixed[7:6] == VC_SEL;
  end

  // Packet FSM with all outputs registered; pulses default low every cycle
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      {sync_wait_q, payload_valid_q, payload_last_q, in_frame_q, in_line_q} <= '0;
      {frame_start_q, frame_end_q, line_start_q, line_end_q, ecc_corrected_q, ecc_error_q} <= '0;
      {payload_q, payload_keep_q, data_type_q, word_count_q, ecc_err_cnt_q} <= '0;
      {remaining_q, data_left_q, vc_ok_q} <= '0;
    end else begin
      {frame_start_q, frame_end_q, line_start_q, line_end_q, ecc_corrected_q, ecc_error_q} <= '0;
      {payload_valid_q, payload_last_q, in_line_q} <= '0;
      payload_keep_q <= 4'd0;
      sync_wait_q <= (state_q == GAP) && data_valid_i;
      case (state_q)
        IDLE: if (data_valid_i) begin
          state_q <= GAP;
          if (!hdr_ok) begin
            ecc_error_q <= 1'b1;
            ecc_err_cnt_q <= ecc_err_cnt_q + 16'(ecc_err_cnt_q != 16'hFFFF);
          end else begin
            ecc_corrected_q <= syn != 6'd0;
            if (vc_ok) begin
              data_type_q <= dt;
              word_count_q <= wc;
            end
            if (dt >= DT_LONG_MIN) begin
              state_q <= PAYLOAD;
              remaining_q <= 16'((17'(wc) + 17'd5) >> 2);
              data_left_q <= 16'((17'(wc) + 17'd3) >> 2);
              vc_ok_q <= vc_ok;
            end else if (vc_ok) begin
              frame_start_q <= dt == DT_FS;
              frame_end_q <= dt == DT_FE;
              line_start_q <= dt == DT_LS;
              line_end_q <= dt == DT_LE;
              in_frame_q <= (dt == DT_FS) ? 1'b1 : (dt == DT_FE) ? 1'b0 : in_frame_q;
            end
          end
        end
        PAYLOAD: if (!data_valid_i) begin
          state_q <= IDLE;
        end else begin
          remaining_q <= remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_q <= GAP;
          if (data_left_q != 16'd0) begin
            data_left_q <= data_left_q - 16'd1;
            payload_q <= data_i;
            payload_valid_q <= vc_ok_q;
            in_line_q <= vc_ok_q;
            payload_last_q <= vc_ok_q && (data_left_q == 16'd1);
            payload_keep_q <= !vc_ok_q ? 4'd0 :
                              (data_left_q != 16'd1 || word_count_q[1:0] == 2'd0) ? 4'hF :
                              (4'd1 << word_count_q[1:0]) - 4'd1;
          end
        end
        default: if (!data_valid_i) state_q <= IDLE;
      endcase
    end
  end

  assign sync_wait_o = sync_wait_q;
  assign payload_o = payload_q;
  assign payload_valid_o = payload_valid_q;
  assign payload_keep_o = payload_keep_q;
  assign payload_last_o = payload_last_q;
  assign data_type_o = data_type_q;
  assign word_count_o = word_count_q;
  assign in_frame_o = in_frame_q;
  assign in_line_o = in_line_q;
  assign frame_start_o = frame_start_q;
  assign frame_end_o = frame_end_q;
  assign line_start_o = line_start_q;
  assign line_end_o = line_end_q;
  assign ecc_corrected_o = ecc_corrected_q;
  assign ecc_error_o = ecc_error_q;
  assign ecc_err_cnt_o = ecc_err_cnt_q;
endmodule
